// File: rtl/rep_cmps_seq_pkg.sv
// Shared types and constants for the CMPS / REPE / REPNE CMPS sequencer.
// Optional build macro REP_INTR_EN is handled by the interface and top, not here.
package rep_cmps_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHK,
      ST_RD1,
      ST_RD2,
      ST_UPD_SI,
      ST_UPD_DI,
      ST_FIN
   } state_t;

   localparam logic [1:0] REP_NONE = 2'b00;
   localparam logic [1:0] REP_E    = 2'b01;
   localparam logic [1:0] REP_NE   = 2'b10;
   localparam logic [1:0] REP_RSVD = 2'b11;

   localparam logic [3:0] ALU1_OP_PTRCH = 4'b1010;
   localparam logic [3:0] ALU1_OP_PASS  = 4'b0100;

   // The reserved encoding behaves like a plain CMPS.
   function automatic logic is_rep(input logic [1:0] rt);
      return (rt == REP_E) || (rt == REP_NE);
   endfunction

endpackage

// File: rtl/rep_cmps_seq_if.sv
// Execute-stage bundle between the CMPS sequencer and the memory/ALU1/regfile side.
// REP_INTR_EN adds intr_pend / intr_exit.
interface rep_cmps_seq_if #(parameter int ECX_W = 32);

   logic             start;
   logic [1:0]       rep_type;
   logic [ECX_W-1:0] ecx_in;
   logic             mem_req;
   logic             mem_sel;
   logic             mem_ack;
   logic             latch_mem;
   logic             cmps_zf;
   logic             ld_flags;
   logic [3:0]       alu1_op;
   logic             sr1_sel;
   logic             ld_esi;
   logic             ld_edi;
   logic             ld_ecx;
   logic [ECX_W-1:0] ecx_out;
   logic             busy;
   logic             done;
`ifdef REP_INTR_EN
   logic             intr_pend;
   logic             intr_exit;

   modport master (
      input  start, rep_type, ecx_in, mem_ack, cmps_zf, intr_pend,
      output mem_req, mem_sel, latch_mem, ld_flags, alu1_op, sr1_sel,
             ld_esi, ld_edi, ld_ecx, ecx_out, busy, done, intr_exit
   );

   modport slave (
      output start, rep_type, ecx_in, mem_ack, cmps_zf, intr_pend,
      input  mem_req, mem_sel, latch_mem, ld_flags, alu1_op, sr1_sel,
             ld_esi, ld_edi, ld_ecx, ecx_out, busy, done, intr_exit
   );
`else
   modport master (
      input  start, rep_type, ecx_in, mem_ack, cmps_zf,
      output mem_req, mem_sel, latch_mem, ld_flags, alu1_op, sr1_sel,
             ld_esi, ld_edi, ld_ecx, ecx_out, busy, done
   );

   modport slave (
      output start, rep_type, ecx_in, mem_ack, cmps_zf,
      input  mem_req, mem_sel, latch_mem, ld_flags, alu1_op, sr1_sel,
             ld_esi, ld_edi, ld_ecx, ecx_out, busy, done
   );
`endif

endinterface

// File: rtl/rep_cmps_seq_cnt.sv
// rep_cnt: loadable down-counter holding the working ECX copy, with zero detect
// on both the current value and the value after one more decrement.
module rep_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count_m1,
   output logic         is_zero,
   output logic         m1_is_zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec) begin
         cnt_q <= count_m1;
      end
   end

   // Wraps modulo 2^W; the sequencer never decrements a zero count.
   assign count_m1   = cnt_q - W'(1);
   assign is_zero    = (cnt_q == '0);
   assign m1_is_zero = (count_m1 == '0);

endmodule

// File: rtl/rep_cmps_seq.sv
// Execute-stage sequencer for CMPS and REPE/REPNE CMPS; owns ALU1 while busy.
// Build macro REP_INTR_EN enables interrupt exit between REP iterations.
module rep_cmps_seq
   import rep_cmps_seq_pkg::*;
#(
   parameter int ECX_W = 32
) (
   input logic             clk,
   input logic             rst_n,
   rep_cmps_seq_if.master  bus
);

   state_t state_q, state_d;
   logic [1:0] rep_q;
   logic       zf_q;

   logic             cnt_load, cnt_dec, cnt_zero, cnt_m1_zero;
   logic [ECX_W-1:0] cnt_m1;
   logic             rep_active, iter_last, zf_cap;

   logic             mem_req, mem_sel, latch_mem, ld_flags, sr1_sel;
   logic             ld_esi, ld_edi, ld_ecx;
   logic [3:0]       alu1_op;
   logic [ECX_W-1:0] ecx_out;
`ifdef REP_INTR_EN
   logic             intr_q, intr_set;
`endif

   rep_cnt #(.W(ECX_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (cnt_load),
      .load_val   (bus.ecx_in),
      .dec        (cnt_dec),
      .count_m1   (cnt_m1),
      .is_zero    (cnt_zero),
      .m1_is_zero (cnt_m1_zero)
   );

   assign rep_active = is_rep(rep_q);
   assign iter_last  = !rep_active || cnt_m1_zero ||
                       ((rep_q == REP_E)  && !zf_q) ||
                       ((rep_q == REP_NE) &&  zf_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rep_q   <= REP_NONE;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cnt_load) rep_q <= bus.rep_type;
         if (zf_cap)   zf_q  <= bus.cmps_zf;
      end
   end

`ifdef REP_INTR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         intr_q <= 1'b0;
      end else if (intr_set) begin
         intr_q <= 1'b1;
      end else if (state_q == ST_FIN) begin
         intr_q <= 1'b0;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      zf_cap    = 1'b0;
      mem_req   = 1'b0;
      mem_sel   = 1'b0;
      latch_mem = 1'b0;
      ld_flags  = 1'b0;
      alu1_op   = ALU1_OP_PASS;
      sr1_sel   = 1'b0;
      ld_esi    = 1'b0;
      ld_edi    = 1'b0;
      ld_ecx    = 1'b0;
      ecx_out   = '0;
`ifdef REP_INTR_EN
      intr_set  = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               cnt_load = 1'b1;
               state_d  = ST_CHK;
            end
         end
         // A REP with zero count finishes without touching memory or flags.
         ST_CHK: state_d = (rep_active && cnt_zero) ? ST_FIN : ST_RD1;
         ST_RD1: begin
            mem_req = 1'b1;
            if (bus.mem_ack) begin
               latch_mem = 1'b1;
               state_d   = ST_RD2;
            end
         end
         ST_RD2: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            if (bus.mem_ack) begin
               ld_flags = 1'b1;
               zf_cap   = 1'b1;
               state_d  = ST_UPD_SI;
            end
         end
         ST_UPD_SI: begin
            alu1_op = ALU1_OP_PTRCH;
            ld_esi  = 1'b1;
            state_d = ST_UPD_DI;
         end
         ST_UPD_DI: begin
            alu1_op = ALU1_OP_PTRCH;
            sr1_sel = 1'b1;
            ld_edi  = 1'b1;
            if (rep_active) begin
               ld_ecx  = 1'b1;
               ecx_out = cnt_m1;
               cnt_dec = 1'b1;
            end
            if (iter_last) begin
               state_d = ST_FIN;
`ifdef REP_INTR_EN
            end else if (bus.intr_pend) begin
               intr_set = 1'b1;
               state_d  = ST_FIN;
`endif
            end else begin
               state_d = ST_RD1;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.mem_req   = mem_req;
   assign bus.mem_sel   = mem_sel;
   assign bus.latch_mem = latch_mem;
   assign bus.ld_flags  = ld_flags;
   assign bus.alu1_op   = alu1_op;
   assign bus.sr1_sel   = sr1_sel;
   assign bus.ld_esi    = ld_esi;
   assign bus.ld_edi    = ld_edi;
   assign bus.ld_ecx    = ld_ecx;
   assign bus.ecx_out   = ecx_out;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_FIN);
`ifdef REP_INTR_EN
   assign bus.intr_exit = (state_q == ST_FIN) && intr_q;
`endif

endmodule
